// File: rtl/vga_ball_pkg.sv
// vga_ball_pkg: shared screen geometry, palette and ball state type for the multi-ball renderer
package vga_ball_pkg;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam logic [11:0] WALL_COLOR  = 12'h00f;
    localparam logic [11:0] EMPTY_COLOR = 12'h700;
    localparam logic [11:0] FLASH_COLOR = 12'hfff;
    localparam logic [11:0] BALL_COLORS [8] = '{
        12'hf00, 12'h0f0, 12'hff0, 12'hf0f, 12'h0ff, 12'hf80, 12'h8f0, 12'h08f
    };
    // dx/dy set means moving toward smaller coordinates
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       dx;
        logic       dy;
    } ball_t;
endpackage

// File: rtl/ball_mover.sv
// ball_mover: one ball's position, wall bounce, pixel hit test and optional VGA_BALL_FLASH_EN flash
module ball_mover
    import vga_ball_pkg::*;
#(
    parameter int IDX       = 0,
    parameter int BALL_SIZE = 8,
    parameter int WALL_W    = 5,
    parameter int SPEED     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        move,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    output logic        hit,
    output logic        bounce,
    output logic [11:0] color
);
    localparam logic [9:0] X_MIN = 10'(WALL_W);
    localparam logic [9:0] Y_MIN = 10'(WALL_W);
    localparam logic [9:0] X_MAX = 10'(H_ACTIVE - WALL_W - BALL_SIZE);
    localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - WALL_W - BALL_SIZE);
    localparam logic [9:0] SP    = 10'(SPEED);
    localparam logic [9:0] BS    = 10'(BALL_SIZE);
    localparam logic [9:0] X0    = 10'(WALL_W + 16 + 40 * IDX);
    localparam logic [9:0] Y0    = 10'(WALL_W + 16 + 24 * IDX);
    localparam logic       DX0   = IDX[0];
    localparam logic       DY0   = IDX[1];

    ball_t b, nb;
    logic bx, by;

    always_comb begin
        bx    = b.dx ? (b.x <= X_MIN + SP) : (b.x + SP >= X_MAX);
        by    = b.dy ? (b.y <= Y_MIN + SP) : (b.y + SP >= Y_MAX);
        nb.x  = bx ? (b.dx ? X_MIN : X_MAX) : (b.dx ? b.x - SP : b.x + SP);
        nb.y  = by ? (b.dy ? Y_MIN : Y_MAX) : (b.dy ? b.y - SP : b.y + SP);
        nb.dx = b.dx ^ bx;
        nb.dy = b.dy ^ by;
    end

    assign bounce = bx | by;
    assign hit = hcount >= b.x && hcount < b.x + BS && vcount >= b.y && vcount < b.y + BS;

    always_ff @(posedge clk)
        if (rst) b <= '{x: X0, y: Y0, dx: DX0, dy: DY0};
        else if (move) b <= nb;

`ifdef VGA_BALL_FLASH_EN
    logic [1:0] flash;

    always_ff @(posedge clk)
        if (rst) flash <= '0;
        else if (move) flash <= bounce ? 2'd3 : (|flash ? flash - 2'd1 : flash);

    assign color = |flash ? FLASH_COLOR : BALL_COLORS[IDX];
`else
    assign color = BALL_COLORS[IDX];
`endif
endmodule

// File: rtl/vga_multi_ball.sv
// vga_multi_ball: bouncing balls inside a walled frame; VGA_BALL_FLASH_EN adds bounce flashing
module vga_multi_ball
    import vga_ball_pkg::*;
#(
    parameter int NUM_BALLS = 4,
    parameter int BALL_SIZE = 8,
    parameter int WALL_W    = 5,
    parameter int SPEED     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pixpulse,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        hblank,
    input  logic        vblank,
    input  logic        pause,
    output logic [3:0]  vgaRed,
    output logic [3:0]  vgaGreen,
    output logic [3:0]  vgaBlue,
    output logic [15:0] frame_cnt,
    output logic [15:0] wall_hits
);
    logic vblank_d1, move, step, wall;
    logic [11:0] current_pixel, pix_next;
    logic [NUM_BALLS-1:0] hit, bounce;
    logic [NUM_BALLS-1:0][11:0] colors;

    assign move = pixpulse & vblank & ~vblank_d1;
    assign step = move & ~pause;

    for (genvar i = 0; i < NUM_BALLS; i++) begin : g_ball
        ball_mover #(
            .IDX(i), .BALL_SIZE(BALL_SIZE), .WALL_W(WALL_W), .SPEED(SPEED)
        ) u_ball (
            .clk(clk), .rst(rst), .move(step), .hcount(hcount), .vcount(vcount),
            .hit(hit[i]), .bounce(bounce[i]), .color(colors[i])
        );
    end

    assign wall = hcount < 10'(WALL_W) || hcount >= 10'(H_ACTIVE - WALL_W) ||
                  vcount < 10'(WALL_W) || vcount >= 10'(V_ACTIVE - WALL_W);

    // walk from the highest index down so the lowest covering ball wins
    always_comb begin
        pix_next = EMPTY_COLOR;
        for (int i = NUM_BALLS - 1; i >= 0; i--) pix_next = hit[i] ? colors[i] : pix_next;
        pix_next = wall ? WALL_COLOR : pix_next;
    end

    always_ff @(posedge clk)
        if (rst) begin
            vblank_d1     <= 1'b0;
            current_pixel <= '0;
            frame_cnt     <= '0;
            wall_hits     <= '0;
        end else begin
            if (pixpulse) begin
                vblank_d1     <= vblank;
                current_pixel <= pix_next;
            end
            if (step) begin
                frame_cnt <= frame_cnt + 16'd1;
                if (|bounce && wall_hits != 16'hffff) wall_hits <= wall_hits + 16'd1;
            end
        end

    assign {vgaRed, vgaGreen, vgaBlue} = (~hblank & ~vblank) ? current_pixel : 12'h000;
endmodule

// File: tb/tb_vga_multi_ball.sv
// tb_vga_multi_ball: directed checks of motion, bounces, pause, colour priority and blanking
module tb_vga_multi_ball;
    import vga_ball_pkg::*;

`ifdef VGA_BALL_FLASH_EN
    localparam logic [11:0] FL = 12'hfff;
`else
    localparam logic [11:0] FL = 12'hf00;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1, pixpulse = 1'b1, hblank = 1'b0, vblank = 1'b0, pause = 1'b0;
    logic [9:0] hcount = '0, vcount = '0;
    logic [3:0] r1, g1, b1, r2, g2, b2;
    logic [15:0] fc1, wh1, fc2, wh2;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    vga_multi_ball #(.NUM_BALLS(1)) dut1 (
        .clk(clk), .rst(rst), .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
        .hblank(hblank), .vblank(vblank), .pause(pause),
        .vgaRed(r1), .vgaGreen(g1), .vgaBlue(b1), .frame_cnt(fc1), .wall_hits(wh1)
    );

    vga_multi_ball #(.NUM_BALLS(2), .BALL_SIZE(48)) dut2 (
        .clk(clk), .rst(rst), .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
        .hblank(hblank), .vblank(vblank), .pause(pause),
        .vgaRed(r2), .vgaGreen(g2), .vgaBlue(b2), .frame_cnt(fc2), .wall_hits(wh2)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse(input int n);
        repeat (n) begin
            @(negedge clk) vblank = 1'b1;
            @(negedge clk) vblank = 1'b0;
        end
    endtask

    task automatic probe(input logic [9:0] x, input logic [9:0] y, input logic hb,
                         output logic [11:0] p1, output logic [11:0] p2);
        @(negedge clk) begin hcount = x; vcount = y; hblank = hb; end
        @(negedge clk) begin p1 = {r1, g1, b1}; p2 = {r2, g2, b2}; end
        hblank = 1'b0;
    endtask

    task automatic px1(input string tag, input logic [9:0] x, input logic [9:0] y, input logic [11:0] exp);
        logic [11:0] p1, p2;
        probe(x, y, 1'b0, p1, p2);
        check(tag, {4'h0, p1}, {4'h0, exp});
    endtask

    task automatic px2(input string tag, input logic [9:0] x, input logic [9:0] y, input logic hb, input logic [11:0] exp);
        logic [11:0] p1, p2;
        probe(x, y, hb, p1, p2);
        check(tag, {4'h0, p2}, {4'h0, exp});
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk) check("rst_rgb", {4'h0, r1, g1, b1}, 16'h0000);
        vblank = 1'b1;
        @(negedge clk) begin vblank = 1'b0; rst = 1'b0; end
        @(negedge clk);
        check("rst_frame", fc1, 16'd0);
        check("rst_hits", wh1, 16'd0);
        px1("rst_ball_tl", 21, 21, 12'hf00);
        px1("rst_ball_br", 28, 28, 12'hf00);
        px1("rst_left", 20, 21, 12'h700);
        px1("rst_right", 29, 21, 12'h700);
        px1("rst_above", 21, 20, 12'h700);
        px1("wall_l4", 4, 100, 12'h00f);
        px1("wall_l5", 5, 100, 12'h700);
        px1("wall_r635", 635, 100, 12'h00f);
        px1("wall_r634", 634, 100, 12'h700);
        px1("wall_t4", 100, 4, 12'h00f);
        px1("wall_b475", 100, 475, 12'h00f);
        px1("wall_b474", 100, 474, 12'h700);
        px2("overlap", 64, 50, 1'b0, 12'hf00);
        px2("ball1_only", 100, 50, 1'b0, 12'h0f0);
        px2("wall_2_100", 2, 100, 1'b0, 12'h00f);
        px2("empty2", 300, 300, 1'b0, 12'h700);
        px2("hblank", 64, 50, 1'b1, 12'h000);

        pulse(1);
        check("move1_frame", fc1, 16'd1);
        check("move1_frame2", fc2, 16'd1);
        check("move1_hits", wh1, 16'd0);
        px1("move1_tl", 23, 23, 12'hf00);
        px1("move1_old", 22, 23, 12'h700);

        pause = 1'b1;
        pulse(10);
        pause = 1'b0;
        check("pause_frame", fc1, 16'd1);
        check("pause_hits", wh1, 16'd0);
        px1("pause_tl", 23, 23, 12'hf00);
        px1("pause_old", 22, 22, 12'h700);

        pulse(222);
        check("m223_frame", fc1, 16'd223);
        check("m223_hits", wh1, 16'd1);
        px1("m223_tl", 467, 467, FL);
        px1("m223_above", 467, 466, 12'h700);
        px1("m223_br", 474, 474, FL);

        pulse(1);
        px1("m224_tl", 469, 465, FL);
        px1("m224_above", 469, 464, 12'h700);
        px1("m224_left", 468, 465, 12'h700);
        pulse(1);
        px1("m225_tl", 471, 463, FL);
        pulse(1);
        px1("m226_tl", 473, 461, 12'hf00);
        check("m226_hits", wh1, 16'd1);

        pulse(77);
        check("m303_hits", wh1, 16'd2);
        px1("m303_tl", 627, 307, FL);
        px1("m303_left", 626, 307, 12'h700);

        pulse(1);
        check("m304_frame", fc1, 16'd304);
        px1("m304_tl", 625, 305, FL);
        px1("m304_right", 633, 305, 12'h700);
        px1("m304_wall", 635, 305, 12'h00f);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
